bp_nonsynth_if_monitor: RTL and testbench

BP_NONSYNTH_IF_MONITOR -- requirements
Module: bp_nonsynth_if_monitor

---
 rtl/bp_common_pkg.sv | 32 +++
 rtl/bp_nonsynth_if_monitor_chan.sv | 117 +++++++++++
 rtl/bp_nonsynth_if_monitor.sv | 105 ++++++++++
 tb/tb_bp_nonsynth_if_monitor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_common_pkg.sv
// Shared types for the valid/ready interface monitor: error codes, channel
// FSM states and the code-priority helper.
package bp_common_pkg;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_DROP    = 2'd1,
      ERR_DCHG    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } bp_err_code_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } bp_mon_state_e;

   localparam int max_chan_lp    = 32;
   localparam int chan_idx_w_lp  = 5;

   // Several violations in one cycle collapse to the lowest nonzero code.
   function automatic bp_err_code_e bp_err_prio(input logic drop,
                                                input logic dchg,
                                                input logic tout);
      bp_err_code_e code;
      code = ERR_NONE;
      if (drop)      code = ERR_DROP;
      else if (dchg) code = ERR_DCHG;
      else if (tout) code = ERR_TIMEOUT;
      return code;
   endfunction

endpackage

// File: rtl/bp_nonsynth_if_monitor_chan.sv
// One monitored valid/ready channel: IDLE/PEND tracker, payload capture,
// stall counter, saturating handshake counter and error report.
module bp_nonsynth_if_monitor_chan
   import bp_common_pkg::*;
#(
   parameter int data_width_p    = 64,
   parameter int timeout_p       = 1024,
   parameter int count_width_p   = 32,
   parameter int halt_on_error_p = 0,
   parameter int chan_id_p       = 0
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     en_i,
   input  logic                     v_i,
   input  logic                     ready_i,
   input  logic [data_width_p-1:0]  data_i,
   output logic [1:0]               det_code_o,
   output logic                     err_v_o,
   output logic [count_width_p-1:0] txn_count_o
);

   localparam int stall_w_lp = $clog2(timeout_p + 1);
   localparam logic [stall_w_lp-1:0] timeout_lp = stall_w_lp'(timeout_p);

   bp_mon_state_e             state_q, state_d;
   logic [data_width_p-1:0]   data_q, data_d;
   logic [stall_w_lp-1:0]     stall_q, stall_d;
   logic [count_width_p-1:0]  txn_q, txn_d;
   logic                      err_v_q, err_v_d;
   logic                      drop, dchg, tout;
   bp_err_code_e              err_code;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      stall_d = stall_q;
      txn_d   = txn_q;
      drop    = 1'b0;
      dchg    = 1'b0;
      tout    = 1'b0;

      if (v_i && ready_i && (txn_q != '1)) txn_d = txn_q + count_width_p'(1);

      case (state_q)
         ST_IDLE: begin
            if (v_i && !ready_i) begin
               state_d = ST_PEND;
               data_d  = data_i;
               stall_d = stall_w_lp'(1);
            end
         end
         ST_PEND: begin
            if (!v_i) begin
               drop    = 1'b1;
               state_d = ST_IDLE;
               stall_d = '0;
            end else begin
               if (data_i != data_q) begin
                  dchg   = 1'b1;
                  data_d = data_i;
               end
               if (ready_i) begin
                  state_d = ST_IDLE;
                  stall_d = '0;
               end else if (stall_q != timeout_lp) begin
                  // Saturation at the limit makes the timeout fire once per transaction.
                  stall_d = stall_q + stall_w_lp'(1);
                  tout    = (stall_d == timeout_lp);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      err_code = bp_err_prio(drop, dchg, tout);

      if (!en_i) begin
         state_d  = state_q;
         data_d   = data_q;
         stall_d  = stall_q;
         txn_d    = txn_q;
         err_code = ERR_NONE;
      end
      err_v_d = (err_code != ERR_NONE);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         stall_q <= '0;
         txn_q   <= '0;
         err_v_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         stall_q <= stall_d;
         txn_q   <= txn_d;
         err_v_q <= err_v_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_n_i && (err_code != ERR_NONE)) begin
         $display("%0t if_monitor: chan %0d code %0d captured %h current %h",
                  $time, chan_id_p, err_code, data_q, data_i);
         if (halt_on_error_p != 0)
            $fatal(1, "if_monitor: halting on error, chan %0d code %0d", chan_id_p, err_code);
      end
   end

   assign det_code_o  = err_code;
   assign err_v_o     = err_v_q;
   assign txn_count_o = txn_q;

endmodule

// File: rtl/bp_nonsynth_if_monitor.sv
// Valid/ready protocol monitor: per-channel checkers plus first-error
// arbitration and sticky error summary.
module bp_nonsynth_if_monitor
   import bp_common_pkg::*;
#(
   parameter int num_chan_p      = 4,
   parameter int data_width_p    = 64,
   parameter int timeout_p       = 1024,
   parameter int count_width_p   = 32,
   parameter int halt_on_error_p = 0
) (
   input  logic                                clk_i,
   input  logic                                reset_n_i,
   input  logic                                en_i,
   input  logic [num_chan_p-1:0]               v_i,
   input  logic [num_chan_p-1:0]               ready_i,
   input  logic [num_chan_p*data_width_p-1:0]  data_i,
   input  logic                                clear_i,
   output logic [num_chan_p-1:0]               err_v_o,
   output logic                                err_sticky_o,
   output logic [chan_idx_w_lp-1:0]            first_err_chan_o,
   output logic [1:0]                          first_err_code_o,
   output logic [num_chan_p*count_width_p-1:0] txn_count_o
);

   if (num_chan_p > max_chan_lp || num_chan_p < 1 || timeout_p < 2) begin : g_param_chk
      $fatal(1, "bp_nonsynth_if_monitor: num_chan_p must be 1..32 and timeout_p >= 2");
   end

   logic [num_chan_p-1:0][1:0] det_code;

   for (genvar g = 0; g < num_chan_p; g++) begin : g_chan
      bp_nonsynth_if_monitor_chan #(
         .data_width_p    (data_width_p),
         .timeout_p       (timeout_p),
         .count_width_p   (count_width_p),
         .halt_on_error_p (halt_on_error_p),
         .chan_id_p       (g)
      ) u_chan (
         .clk_i       (clk_i),
         .reset_n_i   (reset_n_i),
         .en_i        (en_i),
         .v_i         (v_i[g]),
         .ready_i     (ready_i[g]),
         .data_i      (data_i[g*data_width_p +: data_width_p]),
         .det_code_o  (det_code[g]),
         .err_v_o     (err_v_o[g]),
         .txn_count_o (txn_count_o[g*count_width_p +: count_width_p])
      );
   end

   logic                     sticky_q, sticky_d;
   logic [chan_idx_w_lp-1:0] first_chan_q, first_chan_d;
   bp_err_code_e             first_code_q, first_code_d;
   logic                     any_err;
   logic [chan_idx_w_lp-1:0] win_chan;
   bp_err_code_e             win_code;

   always_comb begin
      any_err  = 1'b0;
      win_chan = '0;
      win_code = ERR_NONE;
      // Descending scan so the lowest erroring channel is the one left standing.
      for (int c = num_chan_p - 1; c >= 0; c--) begin
         if (det_code[c] != 2'd0) begin
            any_err  = 1'b1;
            win_chan = chan_idx_w_lp'(c);
            win_code = bp_err_code_e'(det_code[c]);
         end
      end

      sticky_d     = sticky_q;
      first_chan_d = first_chan_q;
      first_code_d = first_code_q;
      if (en_i) begin
         if (clear_i) begin
            sticky_d     = 1'b0;
            first_chan_d = '0;
            first_code_d = ERR_NONE;
         end
         if (any_err && !sticky_d) begin
            sticky_d     = 1'b1;
            first_chan_d = win_chan;
            first_code_d = win_code;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         sticky_q     <= 1'b0;
         first_chan_q <= '0;
         first_code_q <= ERR_NONE;
      end else begin
         sticky_q     <= sticky_d;
         first_chan_q <= first_chan_d;
         first_code_q <= first_code_d;
      end
   end

   assign err_sticky_o     = sticky_q;
   assign first_err_chan_o = first_chan_q;
   assign first_err_code_o = first_code_q;

endmodule

// File: tb/tb_bp_nonsynth_if_monitor.sv
// Directed and randomized bench for bp_nonsynth_if_monitor with a
// transaction-level reference model.
module tb_bp_nonsynth_if_monitor;

   localparam int NC      = 4;
   localparam int DW      = 16;
   localparam int TO      = 4;
   localparam int CW      = 4;
   localparam int TXN_MAX = (1 << CW) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic              clr = 1'b0;
   logic [NC-1:0]     v = '0;
   logic [NC-1:0]     rdy = '0;
   logic [NC*DW-1:0]  data = '0;
   logic [NC-1:0]     err_v;
   logic              sticky;
   logic [4:0]        fchan;
   logic [1:0]        fcode;
   logic [NC*CW-1:0]  txn;

   int checks = 0;
   int errors = 0;

   // Reference model: a pending transaction remembers its payload and the
   // enabled-cycle number it started on; its age is derived from that.
   bit             m_pend [NC];
   logic [DW-1:0]  m_cap  [NC];
   int             m_start[NC];
   int             m_txn  [NC];
   logic [NC-1:0]  m_errv;
   bit             m_sticky;
   int             m_fchan, m_fcode;
   int             ecyc = 0;

   bp_nonsynth_if_monitor #(
      .num_chan_p      (NC),
      .data_width_p    (DW),
      .timeout_p       (TO),
      .count_width_p   (CW),
      .halt_on_error_p (0)
   ) dut (
      .clk_i            (clk),
      .reset_n_i        (rst_n),
      .en_i             (en),
      .v_i              (v),
      .ready_i          (rdy),
      .data_i           (data),
      .clear_i          (clr),
      .err_v_o          (err_v),
      .err_sticky_o     (sticky),
      .first_err_chan_o (fchan),
      .first_err_code_o (fcode),
      .txn_count_o      (txn)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_step();
      bit drop, dchg, tout;
      int code;
      logic [DW-1:0] d;
      m_errv = '0;
      if (!rst_n) begin
         for (int c = 0; c < NC; c++) begin
            m_pend[c] = 0;
            m_txn[c]  = 0;
         end
         m_sticky = 0;
         m_fchan  = 0;
         m_fcode  = 0;
         return;
      end
      if (!en) return;
      ecyc++;
      if (clr) begin
         m_sticky = 0;
         m_fchan  = 0;
         m_fcode  = 0;
      end
      for (int c = 0; c < NC; c++) begin
         d = data[c*DW +: DW];
         drop = 0; dchg = 0; tout = 0;
         if (v[c] && rdy[c] && m_txn[c] < TXN_MAX) m_txn[c]++;
         if (m_pend[c]) begin
            if (!v[c]) begin
               drop = 1;
               m_pend[c] = 0;
            end else begin
               if (d !== m_cap[c]) begin
                  dchg = 1;
                  m_cap[c] = d;
               end
               if (rdy[c]) m_pend[c] = 0;
               else if (ecyc - m_start[c] + 1 == TO) tout = 1;
            end
         end else if (v[c] && !rdy[c]) begin
            m_pend[c]  = 1;
            m_cap[c]   = d;
            m_start[c] = ecyc;
         end
         code = drop ? 1 : dchg ? 2 : tout ? 3 : 0;
         if (code != 0) begin
            m_errv[c] = 1'b1;
            if (!m_sticky) begin
               m_sticky = 1;
               m_fchan  = c;
               m_fcode  = code;
            end
         end
      end
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".err_v"},  64'(err_v),  64'(m_errv));
      chk({tag, ".sticky"}, 64'(sticky), 64'(m_sticky));
      chk({tag, ".fchan"},  64'(fchan),  64'(m_fchan));
      chk({tag, ".fcode"},  64'(fcode),  64'(m_fcode));
      for (int c = 0; c < NC; c++)
         chk($sformatf("%s.txn%0d", tag, c), 64'(txn[c*CW +: CW]), 64'(m_txn[c]));
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic set_ch(input int c, input bit vv, input bit rr, input logic [DW-1:0] dd);
      v[c]   = vv;
      rdy[c] = rr;
      data[c*DW +: DW] = dd;
   endtask

   initial begin
      int pulses;
      int pulse_at;

      rst_n = 0; en = 1;
      cycle("rst"); cycle("rst");
      chk("rst.err_v", 64'(err_v), 0);
      chk("rst.sticky", 64'(sticky), 0);
      chk("rst.first", {fchan, fcode}, 0);
      chk("rst.txn", 64'(txn), 0);
      rst_n = 1;

      // stall three cycles with constant payload, then complete
      set_ch(0, 1, 0, 16'hA5); repeat (3) cycle("stall_ok");
      set_ch(0, 1, 1, 16'hA5); cycle("stall_ok");
      set_ch(0, 0, 0, 16'h0);  cycle("stall_ok");
      chk("stall_ok.txn0", 64'(txn[CW-1:0]), 1);
      chk("stall_ok.sticky", 64'(sticky), 0);

      // valid withdrawn while pending
      set_ch(1, 1, 0, 16'h11); cycle("drop");
      set_ch(1, 0, 0, 16'h0);  cycle("drop");
      chk("drop.err_v", 64'(err_v), 64'(4'b0010));
      chk("drop.fchan", 64'(fchan), 1);
      chk("drop.fcode", 64'(fcode), 1);
      cycle("drop_after");
      chk("drop.pulse_len", 64'(err_v), 0);
      clr = 1; cycle("clear"); clr = 0;
      chk("clear.sticky", 64'(sticky), 0);

      // timeout fires once, on the 4th stalled cycle
      pulses = 0; pulse_at = -1;
      set_ch(2, 1, 0, 16'h22);
      for (int i = 1; i <= 10; i++) begin
         cycle("timeout");
         if (err_v[2]) begin
            pulses++;
            pulse_at = i;
         end
      end
      chk("timeout.pulses", 64'(pulses), 1);
      chk("timeout.pulse_at", 64'(pulse_at), 4);
      chk("timeout.first", {fchan, fcode}, {5'd2, 2'd3});
      set_ch(2, 1, 1, 16'h22); cycle("timeout_done");
      set_ch(2, 0, 0, 16'h0);  cycle("timeout_done");
      clr = 1; cycle("clear2"); clr = 0;

      // simultaneous data change on ch0 and drop on ch3
      set_ch(0, 1, 0, 16'h30); set_ch(3, 1, 0, 16'h33); cycle("multi");
      set_ch(0, 1, 0, 16'h31); set_ch(3, 0, 0, 16'h0);  cycle("multi");
      chk("multi.err_v", 64'(err_v), 64'(4'b1001));
      chk("multi.first", {fchan, fcode}, {5'd0, 2'd2});
      set_ch(0, 1, 1, 16'h31); cycle("multi_done");
      set_ch(0, 0, 0, 16'h0);  cycle("multi_done");

      // clear coincides with a fresh drop: the new error is retained
      set_ch(1, 1, 0, 16'h44); cycle("clr_err");
      set_ch(1, 0, 0, 16'h0); clr = 1; cycle("clr_err"); clr = 0;
      chk("clr_err.sticky", 64'(sticky), 1);
      chk("clr_err.first", {fchan, fcode}, {5'd1, 2'd1});

      // handshake counter saturates
      set_ch(0, 1, 1, 16'h55); repeat (20) cycle("sat");
      set_ch(0, 0, 0, 16'h0);  cycle("sat");
      chk("sat.txn0", 64'(txn[CW-1:0]), 64'(TXN_MAX));

      // disabled cycles neither report nor advance state
      set_ch(2, 1, 0, 16'h66); cycle("en_hold");
      en = 0; set_ch(2, 0, 1, 16'h0); repeat (3) cycle("en_hold");
      chk("en_hold.err_v", 64'(err_v), 0);
      en = 1; set_ch(2, 1, 1, 16'h66); cycle("en_resume");
      chk("en_resume.err_v", 64'(err_v), 0);
      set_ch(2, 0, 0, 16'h0); cycle("en_resume");

      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < NC; c++) begin
            v[c]   = ($urandom_range(0, 3) != 0);
            rdy[c] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) data[c*DW +: DW] = 16'($urandom);
         end
         en    = ($urandom_range(0, 15) != 0);
         clr   = ($urandom_range(0, 19) == 0);
         rst_n = ($urandom_range(0, 63) != 0);
         cycle("rand");
      end
      rst_n = 1; en = 1; clr = 0;

      // reset while every channel is pending
      for (int c = 0; c < NC; c++) set_ch(c, 1, 0, 16'(16'h70 + c));
      cycle("pend_all"); cycle("pend_all");
      rst_n = 0; cycle("mid_rst");
      chk("mid_rst.err_v", 64'(err_v), 0);
      chk("mid_rst.sticky", 64'(sticky), 0);
      chk("mid_rst.first", {fchan, fcode}, 0);
      chk("mid_rst.txn", 64'(txn), 0);
      rst_n = 1;
      for (int c = 0; c < NC; c++) set_ch(c, 0, 0, 16'h0);
      cycle("post_rst");
      chk("post_rst.err_v", 64'(err_v), 0);
      cycle("post_rst");
      chk("post_rst.err_v2", 64'(err_v), 0);
      chk("post_rst.sticky", 64'(sticky), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
